median_window_core: RTL

MEDIAN_WINDOW_CORE -- requirements
Module: median_window_core

---
 rtl/median_window_core_pkg.sv | 33 +++
 rtl/median_window_core_cell.sv | 73 +++++++
 rtl/median_window_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/median_window_core_pkg.sv
// median_window_core_pkg: shared defaults, sort-cell select encoding and the
// window-length normalisation rule used by median_window_core.
// No ports. Optional feature macro used by the core: MEDIAN_MINMAX_EN.
package median_window_core_pkg;

  localparam int DEF_DATA_LENGTH = 32;
  localparam int DEF_WMAX        = 15;
  localparam int DEF_LOG_WMAX    = 4;

  // Next-value source of one sort cell.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_NEW   = 2'd1,
    SEL_LEFT  = 2'd2,
    SEL_RIGHT = 2'd3
  } cell_sel_e;

  // Requested length -> effective odd length in 1..wmax (wmax is odd).
  function automatic int unsigned norm_window(input int unsigned w_req,
                                              input int unsigned wmax);
    int unsigned w;
    w = w_req;
    if (w == 0) begin
      w = 1;
    end else if (w > wmax) begin
      w = wmax;
    end else if (w[0] == 1'b0) begin
      w = w - 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/median_window_core_cell.sv
// median_sort_cell: one entry of the sorted window (register, compare against
// the new and the oldest sample, 4:1 next-value select).
// Ports: clk/reset_n, en_i/clr_i, x_i (new), old_i (oldest), left_i/right_i
// neighbour values, masked compare flags in, raw compare flags out
// (cx_o = x<R, co_o = old<R), val_o current value, nxt_o selected next value.
module median_sort_cell
  import median_window_core_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] old_i,
  input  logic [DATA_LENGTH-1:0] left_i,
  input  logic [DATA_LENGTH-1:0] right_i,
  input  logic                   cx_self_i,
  input  logic                   co_self_i,
  input  logic                   cx_left_i,
  input  logic                   cx_right_i,
  input  logic                   co_right_i,
  output logic                   cx_o,
  output logic                   co_o,
  output logic [DATA_LENGTH-1:0] val_o,
  output logic [DATA_LENGTH-1:0] nxt_o
);

  logic [DATA_LENGTH-1:0] val_q;
  cell_sel_e              sel;

  assign cx_o  = (x_i < val_q);
  assign co_o  = (old_i < val_q);
  assign val_o = val_q;

  // With p = insert slot (#cells <= x) and d = deleted slot (last cell <= old):
  //   d <  p : cells d..p-2 pull from the right, cell p-1 takes x
  //   d >= p : cell p takes x, cells p+1..d pull from the left
  // Equal insert/delete lands on d == p-1 and reloads the same value.
  always_comb begin
    sel = SEL_HOLD;
    if (co_right_i && !cx_right_i) begin
      sel = SEL_RIGHT;
    end else if (cx_left_i && !co_self_i) begin
      sel = SEL_LEFT;
    end else if ((!cx_self_i && cx_right_i && co_right_i) ||
                 (cx_self_i && !cx_left_i && !co_self_i)) begin
      sel = SEL_NEW;
    end
  end

  always_comb begin
    nxt_o = val_q;
    case (sel)
      SEL_NEW:   nxt_o = x_i;
      SEL_LEFT:  nxt_o = left_i;
      SEL_RIGHT: nxt_o = right_i;
      default:   nxt_o = val_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
    end else if (clr_i) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= nxt_o;
    end
  end

endmodule

// File: rtl/median_window_core.sv
// median_window_core: running median over the last W accepted samples, using
// a systolic array of sorted cells plus a circular age FIFO.
// Ports: clk, reset_n (async, active low), flush + w_in (clear, reload W),
// in_valid/in_ready/x_in (sample in), out_valid/median_out (registered, one
// cycle after acceptance once full), fill (samples held).
// Optional: MEDIAN_MINMAX_EN adds min_out/max_out (cell 0 / cell W-1).
module median_window_core
  import median_window_core_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int WMAX        = DEF_WMAX,
  parameter int LOG_WMAX    = DEF_LOG_WMAX
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [LOG_WMAX-1:0]    w_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] x_in,
  output logic                   out_valid,
  output logic [DATA_LENGTH-1:0] median_out,
  output logic [LOG_WMAX-1:0]    fill
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DATA_LENGTH-1:0] min_out,
  output logic [DATA_LENGTH-1:0] max_out
`endif
);

  localparam int IW = (WMAX > 1) ? $clog2(WMAX) : 1;

  logic                   ready_q;
  logic [LOG_WMAX-1:0]    w_q, w_d;
  logic [LOG_WMAX-1:0]    fill_q, fill_d;
  logic [IW-1:0]          wptr_q, wptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_LENGTH-1:0] median_q, median_d;
  logic [DATA_LENGTH-1:0] fifo_q [WMAX];
  logic [DATA_LENGTH-1:0] cell_q [WMAX];
  logic [DATA_LENGTH-1:0] cell_d [WMAX];
  logic                   cx_raw [WMAX];
  logic                   co_raw [WMAX];
  logic                   cx_eff [WMAX];
  logic                   co_eff [WMAX];
  logic                   accept;
  logic                   full;
  logic [DATA_LENGTH-1:0] old_smp;

  assign in_ready   = ready_q & ~flush;
  assign accept     = in_valid & in_ready;
  assign full       = (fill_q == w_q);
  // Once full, the slot about to be overwritten holds the oldest sample.
  assign old_smp    = fifo_q[wptr_q];
  assign out_valid  = out_valid_q;
  assign median_out = median_q;
  assign fill       = fill_q;

  for (genvar i = 0; i < WMAX; i++) begin : g_cell
    logic                   cx_l, cx_r, co_r;
    logic [DATA_LENGTH-1:0] left_v, right_v;

    if (i == 0) begin : g_lo_edge
      assign cx_l   = 1'b0;
      assign left_v = '0;
    end else begin : g_lo_nb
      assign cx_l   = cx_eff[i-1];
      assign left_v = cell_q[i-1];
    end

    if (i == WMAX - 1) begin : g_hi_edge
      assign cx_r    = 1'b1;
      assign co_r    = 1'b1;
      assign right_v = '0;
    end else begin : g_hi_nb
      assign cx_r    = cx_eff[i+1];
      assign co_r    = co_eff[i+1];
      assign right_v = cell_q[i+1];
    end

    // Empty cells behave as +inf for the new sample. While filling, the
    // "deleted" slot is the first empty cell, so nothing real is removed.
    // Cells at or beyond W are inert.
    assign cx_eff[i] = (LOG_WMAX'(i) < fill_q) ? cx_raw[i] : 1'b1;
    assign co_eff[i] = full ? ((LOG_WMAX'(i) < w_q) ? co_raw[i] : 1'b1)
                            : (LOG_WMAX'(i) > fill_q);

    median_sort_cell #(.DATA_LENGTH(DATA_LENGTH)) u_cell (
      .clk        (clk),
      .reset_n    (reset_n),
      .en_i       (accept && (LOG_WMAX'(i) < w_q)),
      .clr_i      (flush),
      .x_i        (x_in),
      .old_i      (old_smp),
      .left_i     (left_v),
      .right_i    (right_v),
      .cx_self_i  (cx_eff[i]),
      .co_self_i  (co_eff[i]),
      .cx_left_i  (cx_l),
      .cx_right_i (cx_r),
      .co_right_i (co_r),
      .cx_o       (cx_raw[i]),
      .co_o       (co_raw[i]),
      .val_o      (cell_q[i]),
      .nxt_o      (cell_d[i])
    );
  end

  always_comb begin
    w_d         = w_q;
    fill_d      = fill_q;
    wptr_d      = wptr_q;
    out_valid_d = 1'b0;
    median_d    = median_q;
    if (flush) begin
      w_d    = LOG_WMAX'(norm_window(32'(w_in), WMAX));
      fill_d = '0;
      wptr_d = '0;
    end else if (accept) begin
      if (!full) begin
        fill_d = fill_q + LOG_WMAX'(1);
      end
      wptr_d      = (wptr_q == IW'(w_q - LOG_WMAX'(1))) ? '0 : wptr_q + IW'(1);
      out_valid_d = (fill_d == w_q);
      if (out_valid_d) begin
        median_d = cell_d[IW'(w_q >> 1)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      w_q         <= LOG_WMAX'(WMAX);
      fill_q      <= '0;
      wptr_q      <= '0;
      out_valid_q <= 1'b0;
      median_q    <= '0;
    end else begin
      ready_q     <= 1'b1;
      w_q         <= w_d;
      fill_q      <= fill_d;
      wptr_q      <= wptr_d;
      out_valid_q <= out_valid_d;
      median_q    <= median_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < WMAX; k++) begin
        fifo_q[k] <= '0;
      end
    end else if (accept) begin
      fifo_q[wptr_q] <= x_in;
    end
  end

`ifdef MEDIAN_MINMAX_EN
  logic [DATA_LENGTH-1:0] min_q, max_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (out_valid_d) begin
      min_q <= cell_d[0];
      max_q <= cell_d[IW'(w_q - LOG_WMAX'(1))];
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;
`endif

endmodule
